requant_pipe: RTL

Pipelined, multi-lane fixed-point requantiser: converts LANES signed Qm.IFRAC words to signed Qn.OFRAC words with selectable rounding and saturation. It carries a valid/ready stream and reports per-lane and cumulative saturation statistics. It sits between the wide accumulator outputs of the linear layers and the narrow activation datapath, and replaces the fixed Q16.16→Q8.8 combinational projector where throughput, back-pressure or rounding control is needed.

---
 rtl/requant_pipe.sv | 123 ++++++++++++
 1 files changed

// File: rtl/requant_pipe.sv
// Multi-lane signed fixed-point requantiser: round (selectable), shift, saturate,
// over a two-stage valid/ready pipeline with saturation statistics.
module requant_pipe #(
  parameter int LANES = 4,
  parameter int IW    = 32,
  parameter int IFRAC = 16,
  parameter int OW    = 16,
  parameter int OFRAC = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  clr_stats,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*IW-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*OW-1:0]   m_data,
  output logic [LANES-1:0]      m_sat,
  output logic                  sat_sticky,
  output logic [CNT_W-1:0]      sat_count
);

  localparam int SH   = IFRAC - OFRAC;
  localparam int SHM1 = (SH > 0) ? SH - 1 : 0;

  typedef logic signed [IW:0] wide_t;

  localparam wide_t HALF = wide_t'(1) << SHM1;
  localparam wide_t MAXV = {{(IW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam wide_t MINV = {{(IW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  // One guard bit above IW keeps in + bias from overflowing.
  function automatic wide_t round_shift(input logic signed [IW-1:0] x,
                                        input logic [1:0] md);
    wide_t ext;
    wide_t bias;
    ext  = wide_t'(x);
    bias = '0;
    if (SH > 0) begin
      case (md)
        2'b01:   bias = HALF;
        2'b10:   bias = HALF - wide_t'(1) + wide_t'({1'b0, x[SH]});
        default: bias = '0;
      endcase
    end
    return (ext + bias) >>> SH;
  endfunction

  // Returns {clamped, value}; clamped is set only when the value changed.
  function automatic logic [OW:0] saturate(input wide_t r);
    if (r > MAXV)      return {1'b1, MAXV[OW-1:0]};
    else if (r < MINV) return {1'b1, MINV[OW-1:0]};
    else               return {1'b0, r[OW-1:0]};
  endfunction

  logic                 vld_p1;
  logic                 vld_p2;
  wide_t                rnd_p1 [LANES];
  logic [LANES*OW-1:0]  data_p2;
  logic [LANES-1:0]     sat_p2;
  logic [OW:0]          sat_res [LANES];
  logic                 ld1;
  logic                 ld2;
  logic                 acc_sat;

  assign ld2     = !vld_p2 || m_ready;
  assign ld1     = !vld_p1 || ld2;
  assign s_ready = !rst && ld1;
  assign acc_sat = vld_p2 && m_ready && (|sat_p2);

  // Stage 1: round and shift; mode is captured with the beat.
  always_ff @(posedge clk) begin
    if (ld1 && s_valid) begin
      for (int k = 0; k < LANES; k++) begin
        rnd_p1[k] <= round_shift(s_data[k*IW +: IW], mode);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sat_res[k] = saturate(rnd_p1[k]);
    end
  end

  // Stage 2: saturate, plus control and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      data_p2    <= '0;
      sat_p2     <= '0;
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else begin
      if (ld1) vld_p1 <= s_valid;
      if (ld2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          for (int k = 0; k < LANES; k++) begin
            data_p2[k*OW +: OW] <= sat_res[k][OW-1:0];
            sat_p2[k]           <= sat_res[k][OW];
          end
        end
      end
      if (clr_stats) begin
        sat_sticky <= 1'b0;
        sat_count  <= '0;
      end else if (acc_sat) begin
        sat_sticky <= 1'b1;
        if (sat_count != '1) sat_count <= sat_count + 1'b1;
      end
    end
  end

  assign m_valid = vld_p2;
  assign m_data  = data_p2;
  assign m_sat   = sat_p2;

endmodule
